icache_controller: RTL and testbench



---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_line_store.sv | 48 ++++
 rtl/icache_controller.sv | 109 ++++++++++
 tb/tb_icache_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM states, block geometry and address-field widths.
package icache_pkg;

    localparam int BLOCK_BYTES     = 16;
    localparam int OFFSET_BITS     = 4;
    localparam int ADDR_BITS       = 32;
    localparam int BLOCK_BITS      = BLOCK_BYTES * 8;
    localparam int BLOCK_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    function automatic int tag_bits(input int index_bits);
        return ADDR_BITS - OFFSET_BITS - index_bits;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: combinational lookup
// port, synchronous fill port, valid bits cleared asynchronously on reset.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [BLOCK_BITS-1:0] data [LINES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays get no reset; the valid bit alone qualifies them,
    // which keeps them mappable to plain RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: same-cycle hits, and on a miss
// a stall while the 16-byte block is fetched and installed.
module icache_controller
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       read,
    input  logic [ADDR_BITS-1:0]       address,
    output logic [31:0]                instruction,
    output logic                       busywait,
    output logic                       mem_read,
    output logic [BLOCK_ADDR_BITS-1:0] mem_address,
    input  logic [BLOCK_BITS-1:0]      mem_readdata,
    input  logic                       mem_busywait
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS);

    state_t state;
    state_t state_next;

    logic [BLOCK_ADDR_BITS-1:0] miss_addr;
    logic [INDEX_BITS-1:0]      addr_index;
    logic [TAG_BITS-1:0]        addr_tag;
    logic [1:0]                 addr_word;
    logic                       line_valid;
    logic [TAG_BITS-1:0]        line_tag;
    logic [BLOCK_BITS-1:0]      line_data;
    logic                       hit;
    logic                       lookup_hit;
    logic                       start_fill;
    logic                       fill_we;
    logic                       unused_byte_offset;

    assign addr_word          = address[3:2];
    assign addr_index         = address[OFFSET_BITS +: INDEX_BITS];
    assign addr_tag           = address[ADDR_BITS-1 -: TAG_BITS];
    assign unused_byte_offset = ^address[1:0];

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_line_store (
        .clock    (clock),
        .reset    (reset),
        .rd_index (addr_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (fill_we),
        .wr_index (miss_addr[INDEX_BITS-1:0]),
        .wr_tag   (miss_addr[BLOCK_ADDR_BITS-1 -: TAG_BITS]),
        .wr_data  (mem_readdata)
    );

    assign hit        = read & line_valid & (line_tag == addr_tag);
    assign lookup_hit = (state == IDLE) & hit;

    assign instruction = lookup_hit ? line_data[{addr_word, 5'd0} +: 32] : 32'd0;
    assign busywait    = read & ~lookup_hit;

    // Memory outputs decode straight from state, so reset drops mem_read at once.
    assign mem_read    = (state == MEM_READ);
    assign mem_address = miss_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                miss_addr <= address[ADDR_BITS-1:OFFSET_BITS];
            end
        end
    end

    // NOTE: every output of this block is defaulted first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_next = state;
        start_fill = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (read && !hit) begin
                    start_fill = 1'b1;
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                fill_we    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: a driver issues fetches and queues
// expectations from a tag-array model; a negedge monitor checks each reply.
module tb_icache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int fails  = 0;

    bit pattern_mode = 1'b0;
    bit mon_en       = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          stall;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0]  m_valid;
    logic [24:0] m_tag [8];

    always #5 clock = ~clock;

    icache_controller #(.INDEX_BITS(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    // Instruction memory: preload image (or a hash pattern for random runs),
    // 16-cycle transfers with busywait low in the last one.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit pat);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (pat) return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
        case (w)
            32'h00:  return 32'h3E800013;
            32'h04:  return 32'h00208093;
            32'h10:  return 32'h40110233;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] ba, input bit pat);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[32*w +: 32] = mem_word({ba, 4'h0} + 32'(4 * w), pat);
        end
        return b;
    endfunction

    logic [3:0] mem_cnt;
    always @(posedge clock or posedge reset) begin
        if (reset) mem_cnt <= 4'd0;
        else if (mem_read) mem_cnt <= mem_cnt + 4'd1;
    end
    assign mem_busywait = !(mem_read && mem_cnt == 4'd15);
    assign mem_readdata = mem_block(mem_address, pattern_mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = '0;
        for (int i = 0; i < 8; i++) m_tag[i] = '0;
    endtask

    // Issue one fetch from posedge+1 and hold it until the cache answers.
    task automatic issue(input logic [31:0] a);
        exp_t e;
        int   idx;
        bit   h;
        int   n;
        idx = int'(a[6:4]);
        h   = m_valid[idx] && (m_tag[idx] == a[31:7]);
        if (!h) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:7];
        end
        e.addr  = a;
        e.instr = mem_word(a, pattern_mode);
        e.stall = h ? 0 : 18;
        exp_q.push_back(e);
        read    = 1'b1;
        address = a;
        n = 0;
        @(negedge clock);
        while (busywait && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (busywait) begin
            checks++;
            fails++;
            $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", a, n);
        end
        @(posedge clock);
        #1;
        read = 1'b0;
    endtask

    int stall_cnt = 0;
    int mr_cnt    = 0;
    bit addr_bad  = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (!mon_en || reset) begin
            stall_cnt = 0;
            mr_cnt    = 0;
            addr_bad  = 1'b0;
        end else if (read) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_reply: addr %h with no queued expectation", address);
            end else begin
                if (mem_read) begin
                    mr_cnt++;
                    if (mem_address !== exp_q[0].addr[31:4]) addr_bad = 1'b1;
                end
                if (busywait) begin
                    stall_cnt++;
                end else begin
                    e = exp_q.pop_front();
                    check("instruction", instruction, e.instr);
                    check("stall_cycles", stall_cnt, e.stall);
                    check("mem_read_cycles", mr_cnt, (e.stall == 0) ? 0 : 16);
                    check("mem_address_ok", {31'd0, addr_bad}, 32'd0);
                    stall_cnt = 0;
                    mr_cnt    = 0;
                    addr_bad  = 1'b0;
                end
            end
        end
    end

    initial begin
        int          n;
        int          mr_seen;
        logic [31:0] hi;
        logic [31:0] a;
        int          blk;
        int          wd;

        reset   = 1'b1;
        read    = 1'b0;
        address = 32'h0;
        model_clear();
        repeat (2) @(negedge clock);
        check("rst_busywait_idle", busywait, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_address", mem_address, 28'h0);
        read = 1'b1;
        #1;
        check("rst_busywait_read", busywait, 1'b1);
        check("rst_instruction", instruction, 32'h0);
        read = 1'b0;
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        #1;
        check("post_rst_busywait", busywait, 1'b0);

        @(posedge clock);
        #1;
        issue(32'h00);
        issue(32'h04);
        issue(32'h10);
        issue(32'h00);
        issue(32'h80);
        issue(32'h00);

        // Reset in the 5th MEM_READ cycle of a fill, outside the scoreboard.
        mon_en  = 1'b0;
        read    = 1'b1;
        address = 32'h90;
        n       = 0;
        mr_seen = 0;
        while (mr_seen < 5 && n < 100) begin
            @(negedge clock);
            n++;
            if (mem_read) mr_seen++;
        end
        check("midfill_mem_read_cycles", mr_seen, 5);
        reset = 1'b1;
        #1;
        check("midfill_mem_read_drop", mem_read, 1'b0);
        check("midfill_busywait", busywait, 1'b1);
        check("midfill_instruction", instruction, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        read  = 1'b0;
        model_clear();
        mon_en = 1'b1;
        @(posedge clock);
        #1;
        issue(32'h04);
        issue(32'h90);

        // Idle: no requests, whatever the address.
        for (int i = 0; i < 20; i++) begin
            address = $urandom;
            @(negedge clock);
            check("idle_busywait", busywait, 1'b0);
            check("idle_mem_read", mem_read, 1'b0);
        end

        // Random phase against a hashed memory image.
        mon_en = 1'b0;
        reset  = 1'b1;
        pattern_mode = 1'b1;
        model_clear();
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 250; i++) begin
            blk = $urandom_range(0, 7);
            wd  = $urandom_range(0, 3);
            hi  = ($urandom_range(0, 3) == 3) ? $urandom : 32'($urandom_range(0, 3));
            a   = {hi[24:0], 3'(blk), 2'(wd), 2'b00};
            issue(a);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
